target_ibi_scheduler: RTL and testbench
=======================================

// Module: target_ibi_scheduler
// PURPOSE
// - Sequences target-initiated bus requests: In-Band Interrupts (IBI) from the TTI IBI queue, and Hot-Join (HJ).
// - Sits between the CSR-derived target configuration (IBI enable, retry count, dynamic/HJ address) and the
//   target bus FSM.
// - Waits for the bus condition, issues the request, counts NACK retries and reports a completion status.
// PARAMETERS
// - RETRY_W   3  width of the IBI retry-count field
// - ATTEMPT_W 4  width of the attempt counter; must hold 2**RETRY_W
// PORTS
// - clk_i                  in   1   clock
// - rst_ni                 in   1   reset, asynchronous, active-low
// - ibi_enable_i           in   1   IBI enable from TTI CONTROL
// - ibi_retry_num_i        in   3   extra attempts allowed after a NACK
// - dyn_addr_valid_i       in   1   target dynamic address assigned
// - dyn_addr_i             in   7   target dynamic address
// - hj_enable_i            in   1   Hot-Join allowed
// - hj_req_i               in   1   one-cycle request to perform Hot-Join
// - ibi_req_valid_i        in   1   IBI descriptor present at queue head
// - ibi_req_ready_o        out  1   pop the descriptor (one-cycle pulse at completion)
// - bus_available_i        in   1   Bus Available condition met (bus timers)
// - bus_idle_i             in   1   Bus Idle condition met (bus timers)
// - bus_start_det_i        in   1   START driven by the controller was detected
// - req_valid_o            out  1   request to the bus FSM to drive the address
// - req_ready_i            in   1   bus FSM accepted the request (SDA pulled low)
// - req_addr_o             out  7   address to arbitrate with
// - req_is_hj_o            out  1   the current request is Hot-Join
// - done_i                 in   1   one-cycle pulse: attempt finished
// - acked_i                in   1   qualified by done_i: controller ACKed
// - arb_lost_i             in   1   qualified by done_i: arbitration lost
// - ibi_status_valid_o     out  1   one-cycle status pulse (IBI only)
// - ibi_status_o           out  2   0=ACK, 1=NACK retries exhausted, 2=aborted
// - ibi_attempts_o         out  4   attempts used, valid with the status pulse
// - hj_pending_o           out  1   Hot-Join request outstanding
// BEHAVIOUR
// - Reset values:
//   - All outputs 0.
//   - State IDLE, counters 0.
//   - hj_pending_o clears.
// - hj_pending:
//   - Set by hj_req_i when hj_enable_i=1 and dyn_addr_valid_i=0.
//   - Cleared by an HJ ACK, by dyn_addr_valid_i=1, or by hj_enable_i=0.
// - IDLE:
//   - With dyn_addr_valid_i=1, ibi_enable_i=1 and ibi_req_valid_i=1: go to WAIT_BUS, kind=IBI, attempts=0.
//   - Otherwise, with hj_pending=1 and dyn_addr_valid_i=0: go to WAIT_BUS, kind=HJ.
//   - The two kinds are mutually exclusive by the dynamic-address state.
// - WAIT_BUS:
//   - IBI proceeds to REQ on bus_available_i=1; HJ proceeds to REQ on bus_idle_i=1.
//   - IBI with ibi_enable_i=0: go to REPORT with status 2.
//   - HJ with hj_pending cleared: go to IDLE, no status.
// - REQ:
//   - req_valid_o=1.
//   - req_addr_o = dyn_addr_i for IBI, 7'h02 for HJ.
//   - req_addr_o and req_is_hj_o are registered at REQ entry and held stable while req_valid_o=1.
//   - req_ready_i=1: go to WAIT_DONE and increment attempts (saturating at 2**RETRY_W).
//   - bus_start_det_i=1 before ready: withdraw req_valid_o next cycle and return to WAIT_BUS.
//     Not counted as an attempt.
// - WAIT_DONE, on done_i:
//   - acked_i=1: IBI goes to REPORT with status 0; HJ clears hj_pending and goes to IDLE.
//   - arb_lost_i=1: go to WAIT_BUS; the attempt is refunded (decrement).
//   - NACK, IBI, attempts <= ibi_retry_num_i and ibi_enable_i=1: go to WAIT_BUS (retry).
//   - NACK, IBI, otherwise: go to REPORT with status 1, or status 2 if ibi_enable_i=0.
//   - NACK, HJ: go to WAIT_BUS; retried until hj_pending clears.
// - REPORT (1 cycle):
//   - ibi_status_valid_o=1 and ibi_req_ready_o=1.
//   - ibi_attempts_o = attempts.
//   - Then go to IDLE.
//   - Total attempts on a persistent NACK = ibi_retry_num_i+1.
//   - ibi_retry_num_i=0 means a single attempt.
// - Timing:
//   - ibi_enable_i deassertion in REQ/WAIT_DONE never cuts an attempt; it takes effect at done_i.
//   - Latency IDLE to req_valid_o: 2 cycles when the bus condition is already true.
//   - done_i outside WAIT_DONE is ignored.
//   - ibi_retry_num_i is sampled at each decision (not latched).
// STRUCTURE
// - Shared package:
//   - typedef enum ibi_sched_state_e {IDLE, WAIT_BUS, REQ, WAIT_DONE, REPORT}
//   - typedef enum ibi_status_e {IBI_ACK=0, IBI_NACK=1, IBI_ABORT=2}
//   - localparam HOT_JOIN_ADDR = 7'h02
// - Single module, no sub-modules.
// - One FSM, one attempt counter, one hj_pending flop.
// TESTING
// - DA=0x30, enable=1, retry=0, descriptor valid, bus_available=1, ACK on the first attempt
//   -> req_addr=0x30, status=0, attempts=1, one ready pulse.
// - retry=2, NACK on every attempt -> 3 REQ cycles observed, status=1, attempts=3, single pop.
// - retry=1: arb_lost, then NACK, then ACK -> status=0, attempts=2 (arb-lost refunded).
// - dyn_addr_valid=0, hj_enable=1, hj_req pulse, bus_idle=1 -> req_addr=0x02, req_is_hj=1.
//   - ACK -> hj_pending=0, no status pulse.
//   - Setting dyn_addr_valid while in WAIT_BUS -> IDLE.
// - Enable dropped in WAIT_BUS -> status=2, attempts=0.
// - Enable dropped in WAIT_DONE with NACK -> status=2.
// - rst_ni asserted mid-WAIT_DONE -> all outputs 0, no pop.
// - bus_start_det during REQ -> req_valid withdrawn, attempts unchanged, REQ re-entered.

Source files
------------

// File: rtl/target_ibi_scheduler_pkg.sv
// Shared types and constants for the target IBI / Hot-Join scheduler.
//   ibi_sched_state_e : scheduler FSM states
//   ibi_status_e      : completion status reported with the IBI status pulse
//   HOT_JOIN_ADDR     : reserved address arbitrated during Hot-Join
package target_ibi_scheduler_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BUS,
        REQ,
        WAIT_DONE,
        REPORT
    } ibi_sched_state_e;

    typedef enum logic [1:0] {
        IBI_ACK   = 2'd0,
        IBI_NACK  = 2'd1,
        IBI_ABORT = 2'd2
    } ibi_status_e;

    localparam logic [6:0] HOT_JOIN_ADDR = 7'h02;

endpackage

// File: rtl/target_ibi_scheduler.sv
// Target-initiated bus request scheduler (IBI and Hot-Join).
// Waits for the bus condition, offers the request to the target bus FSM,
// counts NACK retries and reports a one-cycle completion status for IBIs.
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   ibi_enable_i               IBI enable
//   ibi_retry_num_i            extra attempts allowed after a NACK
//   dyn_addr_valid_i/dyn_addr_i dynamic address state
//   hj_enable_i, hj_req_i      Hot-Join permission and one-cycle request
//   ibi_req_valid_i/_ready_o   IBI queue head handshake (ready = pop pulse)
//   bus_available_i/bus_idle_i bus timer conditions
//   bus_start_det_i            controller START seen while offering
//   req_valid_o/req_ready_i    request handshake towards the bus FSM
//   req_addr_o, req_is_hj_o    address and kind of the offered request
//   done_i, acked_i, arb_lost_i attempt completion from the bus FSM
//   ibi_status_valid_o/_o, ibi_attempts_o  IBI completion report
//   hj_pending_o               Hot-Join outstanding
module target_ibi_scheduler
    import target_ibi_scheduler_pkg::*;
#(
    parameter int unsigned RETRY_W   = 3,
    parameter int unsigned ATTEMPT_W = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 ibi_enable_i,
    input  logic [RETRY_W-1:0]   ibi_retry_num_i,
    input  logic                 dyn_addr_valid_i,
    input  logic [6:0]           dyn_addr_i,
    input  logic                 hj_enable_i,
    input  logic                 hj_req_i,
    input  logic                 ibi_req_valid_i,
    output logic                 ibi_req_ready_o,
    input  logic                 bus_available_i,
    input  logic                 bus_idle_i,
    input  logic                 bus_start_det_i,
    output logic                 req_valid_o,
    input  logic                 req_ready_i,
    output logic [6:0]           req_addr_o,
    output logic                 req_is_hj_o,
    input  logic                 done_i,
    input  logic                 acked_i,
    input  logic                 arb_lost_i,
    output logic                 ibi_status_valid_o,
    output logic [1:0]           ibi_status_o,
    output logic [ATTEMPT_W-1:0] ibi_attempts_o,
    output logic                 hj_pending_o
);

    localparam logic [ATTEMPT_W-1:0] ATTEMPT_MAX = ATTEMPT_W'(2 ** RETRY_W);

    ibi_sched_state_e       r_state;
    logic                   r_kind_hj;
    logic [ATTEMPT_W-1:0]   r_attempts;
    logic                   r_hj_pending;
    logic                   r_req_valid;
    logic [6:0]             r_req_addr;
    logic                   r_req_is_hj;
    logic                   r_status_valid;
    logic                   r_pop;
    ibi_status_e            r_status;
    logic [ATTEMPT_W-1:0]   r_attempts_out;

    logic                   w_start_ibi;
    logic                   w_start_hj;
    logic                   w_hj_ack;
    logic                   w_retry_ok;
    logic [ATTEMPT_W-1:0]   w_attempt_inc;
    logic [ATTEMPT_W-1:0]   w_attempt_dec;

    assign w_start_ibi   = dyn_addr_valid_i & ibi_enable_i & ibi_req_valid_i;
    assign w_start_hj    = r_hj_pending & ~dyn_addr_valid_i;
    assign w_hj_ack      = (r_state == WAIT_DONE) & r_kind_hj & done_i & acked_i;
    // Retry limit is read live so a CSR change applies to the next decision.
    assign w_retry_ok    = (r_attempts <= ATTEMPT_W'(ibi_retry_num_i)) & ibi_enable_i;
    assign w_attempt_inc = (r_attempts == ATTEMPT_MAX) ? r_attempts
                                                       : r_attempts + ATTEMPT_W'(1);
    assign w_attempt_dec = (r_attempts == '0) ? '0 : r_attempts - ATTEMPT_W'(1);

    // Hot-Join request flag; any clearing condition wins over a new request.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_hj_pending <= 1'b0;
        end else if (w_hj_ack || dyn_addr_valid_i || !hj_enable_i) begin
            r_hj_pending <= 1'b0;
        end else if (hj_req_i) begin
            r_hj_pending <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state        <= IDLE;
            r_kind_hj      <= 1'b0;
            r_attempts     <= '0;
            r_req_valid    <= 1'b0;
            r_req_addr     <= '0;
            r_req_is_hj    <= 1'b0;
            r_status_valid <= 1'b0;
            r_pop          <= 1'b0;
            r_status       <= IBI_ACK;
            r_attempts_out <= '0;
        end else begin
            // Report outputs are single-cycle pulses set only on REPORT entry.
            r_status_valid <= 1'b0;
            r_pop          <= 1'b0;
            r_status       <= IBI_ACK;
            r_attempts_out <= '0;
            case (r_state)
                IDLE: begin
                    if (w_start_ibi) begin
                        r_state    <= WAIT_BUS;
                        r_kind_hj  <= 1'b0;
                        r_attempts <= '0;
                    end else if (w_start_hj) begin
                        r_state    <= WAIT_BUS;
                        r_kind_hj  <= 1'b1;
                        r_attempts <= '0;
                    end
                end
                WAIT_BUS: begin
                    if (r_kind_hj) begin
                        if (!r_hj_pending) begin
                            r_state <= IDLE;
                        end else if (bus_idle_i) begin
                            r_state     <= REQ;
                            r_req_valid <= 1'b1;
                            r_req_addr  <= HOT_JOIN_ADDR;
                            r_req_is_hj <= 1'b1;
                        end
                    end else if (!ibi_enable_i) begin
                        r_state        <= REPORT;
                        r_status_valid <= 1'b1;
                        r_pop          <= 1'b1;
                        r_status       <= IBI_ABORT;
                        r_attempts_out <= r_attempts;
                    end else if (bus_available_i) begin
                        r_state     <= REQ;
                        r_req_valid <= 1'b1;
                        r_req_addr  <= dyn_addr_i;
                        r_req_is_hj <= 1'b0;
                    end
                end
                REQ: begin
                    if (req_ready_i) begin
                        r_state     <= WAIT_DONE;
                        r_req_valid <= 1'b0;
                        r_attempts  <= w_attempt_inc;
                    end else if (bus_start_det_i) begin
                        // Controller won the bus before we drove SDA: back off, no attempt used.
                        r_state     <= WAIT_BUS;
                        r_req_valid <= 1'b0;
                    end
                end
                WAIT_DONE: begin
                    if (done_i) begin
                        if (acked_i) begin
                            if (r_kind_hj) begin
                                r_state <= IDLE;
                            end else begin
                                r_state        <= REPORT;
                                r_status_valid <= 1'b1;
                                r_pop          <= 1'b1;
                                r_status       <= IBI_ACK;
                                r_attempts_out <= r_attempts;
                            end
                        end else if (arb_lost_i) begin
                            r_state    <= WAIT_BUS;
                            r_attempts <= w_attempt_dec;
                        end else if (r_kind_hj || w_retry_ok) begin
                            r_state <= WAIT_BUS;
                        end else begin
                            r_state        <= REPORT;
                            r_status_valid <= 1'b1;
                            r_pop          <= 1'b1;
                            r_status       <= ibi_enable_i ? IBI_NACK : IBI_ABORT;
                            r_attempts_out <= r_attempts;
                        end
                    end
                end
                REPORT: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ibi_req_ready_o    = r_pop;
    assign req_valid_o        = r_req_valid;
    assign req_addr_o         = r_req_addr;
    assign req_is_hj_o        = r_req_is_hj;
    assign ibi_status_valid_o = r_status_valid;
    assign ibi_status_o       = r_status;
    assign ibi_attempts_o     = r_attempts_out;
    assign hj_pending_o       = r_hj_pending;

endmodule

// File: tb/tb_target_ibi_scheduler.sv
// Bench for target_ibi_scheduler: directed scenarios with literal expectations
// followed by randomized traffic, all checked every cycle against a job model.
module tb_target_ibi_scheduler;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       ibi_enable_i = 1'b1;
    logic [2:0] ibi_retry_num_i = 3'd0;
    logic       dyn_addr_valid_i = 1'b1;
    logic [6:0] dyn_addr_i = 7'h30;
    logic       hj_enable_i = 1'b1;
    logic       hj_req_i = 1'b0;
    logic       ibi_req_valid_i = 1'b0;
    logic       ibi_req_ready_o;
    logic       bus_available_i = 1'b1;
    logic       bus_idle_i = 1'b1;
    logic       bus_start_det_i = 1'b0;
    logic       req_valid_o;
    logic       req_ready_i = 1'b0;
    logic [6:0] req_addr_o;
    logic       req_is_hj_o;
    logic       done_i = 1'b0;
    logic       acked_i = 1'b0;
    logic       arb_lost_i = 1'b0;
    logic       ibi_status_valid_o;
    logic [1:0] ibi_status_o;
    logic [3:0] ibi_attempts_o;
    logic       hj_pending_o;

    target_ibi_scheduler #(.RETRY_W(3), .ATTEMPT_W(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .ibi_enable_i(ibi_enable_i),
        .ibi_retry_num_i(ibi_retry_num_i), .dyn_addr_valid_i(dyn_addr_valid_i),
        .dyn_addr_i(dyn_addr_i), .hj_enable_i(hj_enable_i), .hj_req_i(hj_req_i),
        .ibi_req_valid_i(ibi_req_valid_i), .ibi_req_ready_o(ibi_req_ready_o),
        .bus_available_i(bus_available_i), .bus_idle_i(bus_idle_i),
        .bus_start_det_i(bus_start_det_i), .req_valid_o(req_valid_o),
        .req_ready_i(req_ready_i), .req_addr_o(req_addr_o), .req_is_hj_o(req_is_hj_o),
        .done_i(done_i), .acked_i(acked_i), .arb_lost_i(arb_lost_i),
        .ibi_status_valid_o(ibi_status_valid_o), .ibi_status_o(ibi_status_o),
        .ibi_attempts_o(ibi_attempts_o), .hj_pending_o(hj_pending_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural job model ----------------
    // A job is either absent, waiting for the bus, offered, in flight or reporting.
    localparam int J_NONE = 0, J_WAIT = 1, J_OFFER = 2, J_FLIGHT = 3, J_REPORT = 4;
    int         m_phase = J_NONE;
    bit         m_hj = 0;
    bit         m_pend = 0;
    int         m_used = 0;
    int         m_status = 0;
    logic [6:0] m_addr = '0;
    int         nx_phase;
    bit         hj_acked;

    initial forever begin
        @(posedge clk_i or negedge rst_ni);
        if (!rst_ni) begin
            m_phase = J_NONE; m_hj = 0; m_pend = 0; m_used = 0; m_status = 0;
        end else begin
            nx_phase = m_phase;
            hj_acked = 0;
            if (m_phase == J_NONE) begin
                if (dyn_addr_valid_i && ibi_enable_i && ibi_req_valid_i) begin
                    nx_phase = J_WAIT; m_hj = 0; m_used = 0;
                end else if (m_pend && !dyn_addr_valid_i) begin
                    nx_phase = J_WAIT; m_hj = 1; m_used = 0;
                end
            end else if (m_phase == J_WAIT) begin
                if (m_hj) begin
                    if (!m_pend) nx_phase = J_NONE;
                    else if (bus_idle_i) begin nx_phase = J_OFFER; m_addr = 7'h02; end
                end else if (!ibi_enable_i) begin
                    nx_phase = J_REPORT; m_status = 2;
                end else if (bus_available_i) begin
                    nx_phase = J_OFFER; m_addr = dyn_addr_i;
                end
            end else if (m_phase == J_OFFER) begin
                if (req_ready_i) begin
                    nx_phase = J_FLIGHT;
                    m_used = (m_used < 8) ? m_used + 1 : 8;
                end else if (bus_start_det_i) nx_phase = J_WAIT;
            end else if (m_phase == J_FLIGHT) begin
                if (done_i) begin
                    if (acked_i) begin
                        if (m_hj) begin nx_phase = J_NONE; hj_acked = 1; end
                        else begin nx_phase = J_REPORT; m_status = 0; end
                    end else if (arb_lost_i) begin
                        nx_phase = J_WAIT;
                        m_used = (m_used > 0) ? m_used - 1 : 0;
                    end else if (m_hj) nx_phase = J_WAIT;
                    else if (m_used <= int'(ibi_retry_num_i) && ibi_enable_i) nx_phase = J_WAIT;
                    else begin nx_phase = J_REPORT; m_status = ibi_enable_i ? 1 : 2; end
                end
            end else begin
                nx_phase = J_NONE;
            end
            if (hj_acked || dyn_addr_valid_i || !hj_enable_i) m_pend = 0;
            else if (hj_req_i) m_pend = 1;
            m_phase = nx_phase;
        end
    end

    // ---------------- compare + monitor ----------------
    int         pops = 0, stats = 0, req_rises = 0;
    int         last_status = -1, last_attempts = -1;
    logic       prev_rv = 1'b0;

    initial forever begin
        @(negedge clk_i);
        chk("req_valid", int'(req_valid_o), int'(m_phase == J_OFFER));
        chk("status_valid", int'(ibi_status_valid_o), int'(m_phase == J_REPORT));
        chk("pop", int'(ibi_req_ready_o), int'(m_phase == J_REPORT));
        chk("status", int'(ibi_status_o), (m_phase == J_REPORT) ? m_status : 0);
        chk("attempts", int'(ibi_attempts_o), (m_phase == J_REPORT) ? m_used : 0);
        chk("hj_pending", int'(hj_pending_o), int'(m_pend));
        if (m_phase == J_OFFER) begin
            chk("req_addr", int'(req_addr_o), int'(m_addr));
            chk("req_is_hj", int'(req_is_hj_o), int'(m_hj));
        end
        if (ibi_req_ready_o) pops++;
        if (ibi_status_valid_o) begin
            stats++;
            last_status   = int'(ibi_status_o);
            last_attempts = int'(ibi_attempts_o);
        end
        if (req_valid_o && !prev_rv) req_rises++;
        prev_rv = req_valid_o;
    end

    // ---------------- stimulus ----------------
    int desc_cnt = 0;
    bit rnd_mode = 0;

    task automatic tick();
        @(negedge clk_i);
        if (ibi_req_ready_o && desc_cnt > 0) desc_cnt--;
        if (rnd_mode) begin
            if ($urandom_range(0, 99) < 2) dyn_addr_valid_i = ~dyn_addr_valid_i;
            if ($urandom_range(0, 99) < 5) dyn_addr_i = 7'($urandom_range(8, 119));
            if ($urandom_range(0, 99) < 5) ibi_retry_num_i = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 99) < 4) ibi_enable_i = ~ibi_enable_i;
            if (!ibi_enable_i && $urandom_range(0, 99) < 20) ibi_enable_i = 1'b1;
            hj_enable_i     = ($urandom_range(0, 99) < 90);
            hj_req_i        = ($urandom_range(0, 99) < 6);
            bus_available_i = ($urandom_range(0, 9) < 6);
            bus_idle_i      = ($urandom_range(0, 9) < 5);
            bus_start_det_i = ($urandom_range(0, 9) < 1);
            req_ready_i     = ($urandom_range(0, 9) < 3);
            done_i          = ($urandom_range(0, 9) < 2);
            acked_i         = ($urandom_range(0, 9) < 3);
            arb_lost_i      = ($urandom_range(0, 9) < 2);
            if (desc_cnt == 0 && $urandom_range(0, 9) < 3) desc_cnt = $urandom_range(1, 3);
        end
        ibi_req_valid_i = (desc_cnt > 0);
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_req(output bit ok);
        ok = 0;
        for (int k = 0; k < 40; k++) begin
            if (req_valid_o) begin ok = 1; break; end
            tick();
        end
        if (!ok) begin
            n_tests++; n_fail++;
            $display("FAIL req_timeout: got no req_valid within 40 cycles (t=%0t)", $time);
        end
    endtask

    // outcome: 0 = ACK, 1 = NACK, 2 = arbitration lost
    task automatic attempt(input int outcome);
        bit ok;
        wait_req(ok);
        if (!ok) return;
        req_ready_i = 1'b1; tick(); req_ready_i = 1'b0; tick();
        done_i = 1'b1; acked_i = (outcome == 0); arb_lost_i = (outcome == 2); tick();
        done_i = 1'b0; acked_i = 1'b0; arb_lost_i = 1'b0;
    endtask

    int p0, r0, s0, lat;
    bit ok;

    initial begin
        settle(3);
        chk("reset_outputs", int'({req_valid_o, req_addr_o, req_is_hj_o, ibi_status_valid_o,
            ibi_req_ready_o, ibi_status_o, ibi_attempts_o, hj_pending_o}), 0);
        rst_ni = 1'b1;
        settle(2);

        // ACK on the first attempt, latency IDLE -> req_valid
        p0 = pops;
        desc_cnt = 1; ibi_req_valid_i = 1'b1;
        lat = 0;
        while (!req_valid_o && lat < 10) begin tick(); lat++; end
        chk("s1_latency", lat, 2);
        chk("s1_addr", int'(req_addr_o), 'h30);
        attempt(0); settle(3);
        chk("s1_status", last_status, 0);
        chk("s1_attempts", last_attempts, 1);
        chk("s1_pops", pops, p0 + 1);

        // persistent NACK with retry=2
        ibi_retry_num_i = 3'd2; p0 = pops; r0 = req_rises; desc_cnt = 1;
        attempt(1); attempt(1); attempt(1); settle(3);
        chk("s2_req_count", req_rises, r0 + 3);
        chk("s2_status", last_status, 1);
        chk("s2_attempts", last_attempts, 3);
        chk("s2_pops", pops, p0 + 1);

        // arb lost is refunded
        ibi_retry_num_i = 3'd1; desc_cnt = 1;
        attempt(2); attempt(1); attempt(0); settle(3);
        chk("s3_status", last_status, 0);
        chk("s3_attempts", last_attempts, 2);

        // Hot-Join
        dyn_addr_valid_i = 1'b0; s0 = stats; settle(2);
        hj_req_i = 1'b1; tick(); hj_req_i = 1'b0;
        wait_req(ok);
        chk("hj_addr", int'(req_addr_o), 2);
        chk("hj_is_hj", int'(req_is_hj_o), 1);
        attempt(0); settle(3);
        chk("hj_cleared", int'(hj_pending_o), 0);
        chk("hj_no_status", stats, s0);
        bus_idle_i = 1'b0; r0 = req_rises;
        hj_req_i = 1'b1; tick(); hj_req_i = 1'b0; settle(3);
        chk("hj_pending_set", int'(hj_pending_o), 1);
        dyn_addr_valid_i = 1'b1; settle(4);
        chk("hj_da_clear", int'(hj_pending_o), 0);
        chk("hj_no_req", req_rises, r0);
        bus_idle_i = 1'b1;

        // enable dropped while waiting for the bus
        bus_available_i = 1'b0; p0 = pops; desc_cnt = 1; settle(3);
        ibi_enable_i = 1'b0; settle(3);
        chk("s6_status", last_status, 2);
        chk("s6_attempts", last_attempts, 0);
        chk("s6_pops", pops, p0 + 1);
        ibi_enable_i = 1'b1; bus_available_i = 1'b1;

        // enable dropped in flight, then NACK
        ibi_retry_num_i = 3'd3; desc_cnt = 1;
        wait_req(ok);
        req_ready_i = 1'b1; tick(); req_ready_i = 1'b0; ibi_enable_i = 1'b0; tick();
        done_i = 1'b1; tick(); done_i = 1'b0; settle(3);
        chk("s7_status", last_status, 2);
        chk("s7_attempts", last_attempts, 1);
        ibi_enable_i = 1'b1;

        // reset in flight
        p0 = pops; desc_cnt = 1;
        wait_req(ok);
        req_ready_i = 1'b1; tick(); req_ready_i = 1'b0; tick();
        rst_ni = 1'b0; desc_cnt = 0; ibi_req_valid_i = 1'b0; #1;
        chk("s8_reset_outputs", int'({req_valid_o, req_addr_o, req_is_hj_o, ibi_status_valid_o,
            ibi_req_ready_o, ibi_status_o, ibi_attempts_o, hj_pending_o}), 0);
        settle(2); rst_ni = 1'b1; settle(4);
        chk("s8_no_pop", pops, p0);

        // START detected while offering
        desc_cnt = 1; ibi_retry_num_i = 3'd0;
        wait_req(ok);
        r0 = req_rises;
        bus_start_det_i = 1'b1; tick(); bus_start_det_i = 1'b0;
        chk("s9_withdrawn", int'(req_valid_o), 0);
        attempt(0); settle(3);
        chk("s9_reoffer", req_rises, r0 + 1);
        chk("s9_status", last_status, 0);
        chk("s9_attempts", last_attempts, 1);

        // randomized traffic
        rnd_mode = 1'b1;
        settle(4000);
        rnd_mode = 1'b0;
        req_ready_i = 1'b0; done_i = 1'b0; hj_req_i = 1'b0; bus_start_det_i = 1'b0;
        settle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
